// File: rtl/mem_access_unit.sv
// MEM-stage access unit: req/ack load/store sequencing, pipeline stall and the MEM/WB register.
// Optional `MEM_TIMEOUT_EN aborts a request that sees no ack within TIMEOUT_CYCLES.
module mem_access_unit #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [1:0]        mem_m_i,
    input  logic [1:0]        wb_m_i,
    input  logic [DATA_W-1:0] aluout_m_i,
    input  logic [DATA_W-1:0] write_data_m_i,
    input  logic [4:0]        write_reg_m_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stall_m_o,
    output logic              exc_m_o,
    output logic [1:0]        wb_w_o,
    output logic [DATA_W-1:0] aluout_w_o,
    output logic [DATA_W-1:0] read_data_w_o,
    output logic [4:0]        write_reg_w_o
);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e            state_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [DATA_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              abort_q;
    logic              exc_q;
    logic [1:0]        wb_w_q;
    logic [DATA_W-1:0] aluout_w_q;
    logic [DATA_W-1:0] read_data_w_q;
    logic [4:0]        write_reg_w_q;

    logic access;
    logic illegal;
    logic fault;
    logic stall;
    logic timeout;

    assign access  = |mem_m_i;
    assign illegal = (mem_m_i == 2'b11) || (aluout_m_i[1:0] != 2'b00);
    assign fault   = access && illegal;
    assign stall   = rst_ni && (((state_q == StIdle) && access && !illegal) || (state_q == StReq));

`ifdef MEM_TIMEOUT_EN
    logic [7:0] cnt_q;

    // Fires on the last allowed REQ cycle; an ack in that same cycle takes priority.
    assign timeout = (state_q == StReq) && !mem_ack_i &&
                     (cnt_q == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (state_q != StReq) begin
            cnt_q <= '0;
        end else if (!mem_ack_i) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout            = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            rdata_q       <= '0;
            abort_q       <= 1'b0;
            exc_q         <= 1'b0;
            wb_w_q        <= '0;
            aluout_w_q    <= '0;
            read_data_w_q <= '0;
            write_reg_w_q <= '0;
        end else begin
            exc_q <= 1'b0;

            // Stalled, faulting or timed-out instructions leave a bubble in MEM/WB.
            if (stall || fault || ((state_q == StDone) && abort_q)) begin
                wb_w_q        <= '0;
                write_reg_w_q <= '0;
            end else begin
                wb_w_q        <= wb_m_i;
                aluout_w_q    <= aluout_m_i;
                write_reg_w_q <= write_reg_m_i;
            end
            read_data_w_q <= ((state_q == StDone) && !mem_we_q && !abort_q) ? rdata_q : '0;

            unique case (state_q)
                StIdle: begin
                    if (access) begin
                        if (illegal) begin
                            exc_q <= 1'b1;
                        end else begin
                            state_q     <= StReq;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= mem_m_i[1];
                            mem_addr_q  <= aluout_m_i;
                            mem_wdata_q <= write_data_m_i;
                            abort_q     <= 1'b0;
                        end
                    end
                end
                StReq: begin
                    if (mem_ack_i) begin
                        if (!mem_we_q) begin
                            rdata_q <= mem_rdata_i;
                        end
                        mem_req_q <= 1'b0;
                        state_q   <= StDone;
                    end else if (timeout) begin
                        mem_req_q <= 1'b0;
                        abort_q   <= 1'b1;
                        exc_q     <= 1'b1;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign mem_req_o     = mem_req_q;
    assign mem_we_o      = mem_we_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wdata_o   = mem_wdata_q;
    assign stall_m_o     = stall;
    assign exc_m_o       = exc_q;
    assign wb_w_o        = wb_w_q;
    assign aluout_w_o    = aluout_w_q;
    assign read_data_w_o = read_data_w_q;
    assign write_reg_w_o = write_reg_w_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized bench for mem_access_unit; expected behaviour comes from per-instruction
// timing rules (stall = 1 + ack latency, one request per access, bubbles on faults).
module tb_mem_access_unit;

    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;
`ifdef MEM_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    mem_m;
    logic [1:0]    wb_m;
    logic [DW-1:0] aluout_m;
    logic [DW-1:0] write_data_m;
    logic [4:0]    write_reg_m;
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          stall_m;
    logic          exc_m;
    logic [1:0]    wb_w;
    logic [DW-1:0] aluout_w;
    logic [DW-1:0] read_data_w;
    logic [4:0]    write_reg_w;

    int total = 0;
    int bad   = 0;
    int rises = 0;

    mem_access_unit #(
        .DATA_W        (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .mem_m_i       (mem_m),
        .wb_m_i        (wb_m),
        .aluout_m_i    (aluout_m),
        .write_data_m_i(write_data_m),
        .write_reg_m_i (write_reg_m),
        .mem_req_o     (mem_req),
        .mem_we_o      (mem_we),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_rdata_i   (mem_rdata),
        .mem_ack_i     (mem_ack),
        .stall_m_o     (stall_m),
        .exc_m_o       (exc_m),
        .wb_w_o        (wb_w),
        .aluout_w_o    (aluout_w),
        .read_data_w_o (read_data_w),
        .write_reg_w_o (write_reg_w)
    );

    always #5 clk = ~clk;

    always @(posedge mem_req) rises++;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] mm, input logic [1:0] wb, input logic [DW-1:0] alu,
                         input logic [DW-1:0] wd, input logic [4:0] wr);
        mem_m        = mm;
        wb_m         = wb;
        aluout_m     = alu;
        write_data_m = wd;
        write_reg_m  = wr;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, mem_req, 0);
        check({tag, "_we"}, mem_we, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_stall"}, stall_m, 0);
        check({tag, "_exc"}, exc_m, 0);
        check({tag, "_wbw"}, wb_w, 0);
        check({tag, "_aluw"}, aluout_w, 0);
        check({tag, "_rdw"}, read_data_w, 0);
        check({tag, "_wrw"}, write_reg_w, 0);
    endtask

    // Non-memory op: no stall, results one cycle later; a stray ack must be ignored.
    task automatic do_alu(input logic [1:0] wb, input logic [DW-1:0] alu, input logic [4:0] wr);
        int r0 = rises;
        drive(2'b00, wb, alu, $urandom, wr);
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        #1;
        check("alu_stall", stall_m, 0);
        check("alu_req", mem_req, 0);
        tick();
        mem_ack = 1'b0;
        check("alu_wbw", wb_w, wb);
        check("alu_aluw", aluout_w, alu);
        check("alu_wrw", write_reg_w, wr);
        check("alu_rdw", read_data_w, 0);
        check("alu_exc", exc_m, 0);
        check("alu_rises", rises - r0, 0);
    endtask

    // Legal access acked in REQ cycle k; the pipeline holds the inputs while stalled.
    task automatic do_mem(input bit we, input logic [DW-1:0] addr, input logic [DW-1:0] wd,
                          input int k, input logic [DW-1:0] rdata);
        int          r0   = rises;
        logic [1:0]  wb   = 2'($urandom_range(1, 3));
        logic [4:0]  wr   = 5'($urandom_range(1, 31));
        bit          tout = TimeoutEn && (k > int'(TO));
        int          nreq = tout ? int'(TO) : k;
        drive(we ? 2'b10 : 2'b01, wb, addr, wd, wr);
        mem_ack = 1'b0;
        #1;
        check("mem_idle_stall", stall_m, 1);
        check("mem_idle_req", mem_req, 0);
        tick();
        for (int c = 1; c <= nreq; c++) begin
            check("mem_req_stall", stall_m, 1);
            check("mem_req_req", mem_req, 1);
            check("mem_req_we", mem_we, we);
            check("mem_req_addr", mem_addr, addr);
            check("mem_req_wdata", mem_wdata, wd);
            check("mem_req_bubble", wb_w, 0);
            check("mem_req_exc", exc_m, 0);
            if (c == k) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
            end else begin
                mem_rdata = $urandom;
            end
            tick();
            mem_ack = 1'b0;
        end
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        #1;
        check("mem_done_stall", stall_m, 0);
        check("mem_done_req", mem_req, 0);
        check("mem_done_exc", exc_m, tout);
        tick();
        mem_ack = 1'b0;
        check("mem_wbw", wb_w, tout ? 2'b00 : wb);
        check("mem_wrw", write_reg_w, tout ? 5'd0 : wr);
        if (!tout) check("mem_aluw", aluout_w, addr);
        check("mem_rdw", read_data_w, (!tout && !we) ? rdata : 0);
        check("mem_exc_after", exc_m, 0);
        check("mem_rises", rises - r0, 1);
    endtask

    // Faulting access: no request, one-cycle exception, bubble; followed by a NOP.
    task automatic do_illegal(input logic [1:0] mm, input logic [DW-1:0] alu);
        int         r0 = rises;
        logic [1:0] wb = 2'($urandom_range(1, 3));
        drive(mm, 2'b11, alu, $urandom, 5'($urandom_range(1, 31)));
        #1;
        check("ill_stall", stall_m, 0);
        check("ill_req", mem_req, 0);
        tick();
        check("ill_exc", exc_m, 1);
        check("ill_wbw", wb_w, 0);
        check("ill_wrw", write_reg_w, 0);
        check("ill_req_after", mem_req, 0);
        check("ill_rises", rises - r0, 0);
        drive(2'b00, wb, 32'h40, 0, 5'd3);
        #1;
        tick();
        check("ill_exc_drop", exc_m, 0);
        check("ill_nop_wbw", wb_w, wb);
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        drive(2'b00, 2'b00, 0, 0, 0);
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        do_alu(2'b10, 32'h55, 5'd7);
        do_mem(1'b0, 32'h200, 32'h0, 3, 32'hDEAD_BEEF);
        do_mem(1'b1, 32'h100, 32'h1234, 1, 32'h0);
        do_illegal(2'b01, 32'h102);
        do_illegal(2'b11, 32'h104);

        for (int i = 0; i < 40; i++) begin
            int sel = $urandom_range(0, 9);
            if (sel < 4) begin
                do_alu(2'($urandom), $urandom, 5'($urandom));
            end else if (sel < 8) begin
                do_mem(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom,
                       $urandom_range(1, 6), $urandom);
            end else if (sel == 8) begin
                do_illegal(2'b11, $urandom & 32'hFFFF_FFFC);
            end else begin
                do_illegal(2'($urandom_range(1, 2)),
                           ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3)));
            end
        end

        // Ack on the last allowed cycle, then one cycle too late (timeout when enabled).
        do_mem(1'b0, 32'h300, 32'h0, int'(TO), 32'hCAFE_F00D);
        do_mem(1'b0, 32'h304, 32'h0, int'(TO) + 1, 32'h1111_2222);
        do_alu(2'b01, 32'h99, 5'd9);

        // Asynchronous reset while a load is outstanding; a late ack must be ignored.
        drive(2'b01, 2'b10, 32'h400, 0, 5'd4);
        #1;
        tick();
        tick();
        check("pre_rst_req", mem_req, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        mem_ack = 1'b1;
        drive(2'b00, 2'b00, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_req", mem_req, 0);
        check("post_rst_stall", stall_m, 0);
        check("post_rst_exc", exc_m, 0);
        mem_ack = 1'b0;
        tick();
        check("post_rst_req2", mem_req, 0);
        do_mem(1'b0, 32'h500, 32'h0, 2, 32'h0BAD_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
